pc_gen: RTL and testbench

Parametrised program-counter generator for the RV32 core's fetch stage. It is the successor to program_counter and keeps its branch-select interface: NOP, PC_ADDER and ALU_OUT. It adds:
- a configurable reset vector
- 2-byte or 4-byte sequential increment (compressed-ready)
- a valid/ready fetch handshake
- trap entry and return with an internal EPC register
- misaligned-target detection
It sits between the branch/ALU datapath and instruction memory.

---
 rtl/pc_gen.sv | 148 ++++++++++++++
 tb/tb_pc_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Purpose : program-counter generator for the RV32 fetch stage (reset vector, seq step, redirects, trap/mret, EPC).
// Latency : redirects and steps appear on pc one cycle after the sampling edge; pc_next is combinational from pc/inst_len.
// Backpr. : pc advances sequentially only on fetch_valid & fetch_ready; redirects flush regardless of fetch_ready.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   en                global enable; 0 freezes pc/epc/state and clears misaligned
//   branch[1:0]       0 NOP, 1 PC_ADDER, 2 ALU_OUT, 3 reserved (NOP)
//   alu_result        ALU_OUT target, bit 0 dropped (JALR semantics)
//   pc_adder_result   PC_ADDER target
//   inst_len          1 = 2-byte instruction (only when C_EXT=1), 0 = 4-byte
//   trap, mret        trap entry / return from trap
//   fetch_valid/ready fetch handshake towards instruction memory
//   pc, pc_next, epc  current fetch address, pc + step, saved trap PC
//   misaligned        one-cycle pulse when a branch target was misaligned
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              C_EXT        = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      branch,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_adder_result,
  input  logic            inst_len,
  input  logic            trap,
  input  logic            mret,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] epc,
  output logic            misaligned
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] BR_NOP      = 2'd0;
  localparam logic [1:0] BR_PC_ADDER = 2'd1;
  localparam logic [1:0] BR_ALU_OUT  = 2'd2;

  // Without the C extension every target must be word aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic              mis_q, mis_d;

  logic [XLEN-1:0]   step;
  logic [XLEN-1:0]   target;
  logic              redirect;
  logic              target_mis;

  // Sequential step: halfword only for compressed instructions with C enabled.
  always_comb begin
    step = XLEN'(4);
    if ((C_EXT != 0) && inst_len) begin
      step = XLEN'(2);
    end
  end

  // Natural modulo-2^XLEN wrap at the top of the address space.
  assign pc_next = pc_q + step;

  // Branch target select; JALR drops bit 0 before the alignment check.
  always_comb begin
    target   = '0;
    redirect = 1'b0;
    case (branch)
      BR_PC_ADDER: begin
        target   = pc_adder_result;
        redirect = 1'b1;
      end
      BR_ALU_OUT: begin
        target   = alu_result & ~XLEN'(1);
        redirect = 1'b1;
      end
      default: begin
        target   = '0;
        redirect = 1'b0;
      end
    endcase
  end

  assign target_mis = (target & ALIGN_MASK) != '0;

  // Next-state: priority trap > mret > misaligned redirect > redirect > advance > stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    mis_d   = 1'b0;
    if (en) begin
      case (state_q)
        BOOT: begin
          // One idle cycle so the first fetch presents RESET_VECTOR with a valid handshake.
          state_d = RUN;
        end
        RUN: begin
          if (trap) begin
            epc_d = pc_q;
            pc_d  = TRAP_VECTOR;
          end else if (mret) begin
            pc_d = epc_q;
          end else if (redirect && target_mis) begin
            epc_d = pc_q;
            pc_d  = TRAP_VECTOR;
            mis_d = 1'b1;
          end else if (redirect) begin
            pc_d = target;
          end else if (fetch_ready) begin
            pc_d = pc_next;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
    end
  end

  assign fetch_valid = (state_q == RUN);
  assign pc          = pc_q;
  assign epc         = epc_q;
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Purpose : self-checking bench for pc_gen, one 4-byte-only instance and one compressed-capable instance.
// Latency : expectations are taken one cycle after each vector is driven.
// Backpr. : fetch_ready is driven per vector to exercise stalls and handshake advance.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  branch;
  logic [31:0] alu_result;
  logic [31:0] pc_adder_result;
  logic        inst_len;
  logic        trap;
  logic        mret;
  logic        fetch_ready;

  logic        fv0, mis0, fv1, mis1;
  logic [31:0] pc0, pn0, epc0, pc1, pn1, epc1;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100), .C_EXT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .branch(branch), .alu_result(alu_result),
    .pc_adder_result(pc_adder_result), .inst_len(inst_len), .trap(trap), .mret(mret),
    .fetch_valid(fv0), .fetch_ready(fetch_ready), .pc(pc0), .pc_next(pn0), .epc(epc0),
    .misaligned(mis0)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100), .C_EXT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .branch(branch), .alu_result(alu_result),
    .pc_adder_result(pc_adder_result), .inst_len(inst_len), .trap(trap), .mret(mret),
    .fetch_valid(fv1), .fetch_ready(fetch_ready), .pc(pc1), .pc_next(pn1), .epc(epc1),
    .misaligned(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  br;
    logic [31:0] alu;
    logic [31:0] pca;
    logic        il;
    logic        trap;
    logic        mret;
    logic        fr;
    logic [31:0] pc;
    logic [31:0] pn;
    logic [31:0] epc;
    logic        fv;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pn;
    logic [31:0] epc;
    logic        fv;
    logic        mis;
  } exp_t;

  vec_t tab[$];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic e, input logic [1:0] br, input logic [31:0] alu,
                     input logic [31:0] pca, input logic il, input logic tr, input logic mr,
                     input logic fr, input logic [31:0] xpc, input logic [31:0] xpn,
                     input logic [31:0] xepc, input logic xfv, input logic xmis);
    vec_t v;
    v.en = e;   v.br = br;   v.alu = alu; v.pca = pca; v.il = il;
    v.trap = tr; v.mret = mr; v.fr = fr;
    v.pc = xpc; v.pn = xpn; v.epc = xepc; v.fv = xfv; v.mis = xmis;
    tab.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, req);
    end
  endtask

  task automatic idle_inputs();
    en = 1'b1; branch = 2'd0; alu_result = '0; pc_adder_result = '0;
    inst_len = 1'b0; trap = 1'b0; mret = 1'b0; fetch_ready = 1'b1;
  endtask

  // Reset both instances and check the BOOT-cycle outputs before the first edge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_pc0", 0, pc0, 32'h80);
    chk("rst_fv0", 0, {31'd0, fv0}, 32'd0);
    chk("rst_epc0", 0, epc0, 32'h0);
    chk("rst_mis0", 0, {31'd0, mis0}, 32'd0);
    chk("rst_pc1", 0, pc1, 32'h80);
    chk("rst_fv1", 0, {31'd0, fv1}, 32'd0);
  endtask

  task automatic run_table(input bit sel);
    exp_t e;
    for (int i = 0; i < tab.size(); i++) begin
      en = tab[i].en; branch = tab[i].br; alu_result = tab[i].alu;
      pc_adder_result = tab[i].pca; inst_len = tab[i].il; trap = tab[i].trap;
      mret = tab[i].mret; fetch_ready = tab[i].fr;
      e.pc = tab[i].pc; e.pn = tab[i].pn; e.epc = tab[i].epc;
      e.fv = tab[i].fv; e.mis = tab[i].mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL sb_empty[%0d]: got empty queue, expected an entry", i);
      end else begin
        e = sb.pop_front();
        if (sel == 1'b0) begin
          chk("A_pc", i, pc0, e.pc);
          chk("A_pc_next", i, pn0, e.pn);
          chk("A_epc", i, epc0, e.epc);
          chk("A_fetch_valid", i, {31'd0, fv0}, {31'd0, e.fv});
          chk("A_misaligned", i, {31'd0, mis0}, {31'd0, e.mis});
        end else begin
          chk("B_pc", i, pc1, e.pc);
          chk("B_pc_next", i, pn1, e.pn);
          chk("B_epc", i, epc1, e.epc);
          chk("B_fetch_valid", i, {31'd0, fv1}, {31'd0, e.fv});
          chk("B_misaligned", i, {31'd0, mis1}, {31'd0, e.mis});
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Phase A: 4-byte-only instance. Columns: en br alu pca il trap mret fr | pc pc_next epc fv mis
    add(1, 0, 0,          0,            0, 0, 0, 1,  32'h80,       32'h84,  32'h0,   1, 0); // BOOT->RUN, pc held
    add(1, 0, 0,          0,            0, 0, 0, 1,  32'h84,       32'h88,  32'h0,   1, 0);
    add(1, 0, 0,          0,            0, 0, 0, 1,  32'h88,       32'h8C,  32'h0,   1, 0);
    add(1, 1, 0,          32'hC0,       0, 0, 0, 0,  32'hC0,       32'hC4,  32'h0,   1, 0); // redirect under stall
    add(1, 0, 0,          0,            0, 0, 0, 0,  32'hC0,       32'hC4,  32'h0,   1, 0);
    add(1, 0, 0,          0,            0, 0, 0, 0,  32'hC0,       32'hC4,  32'h0,   1, 0);
    add(1, 0, 0,          0,            0, 0, 0, 0,  32'hC0,       32'hC4,  32'h0,   1, 0);
    add(1, 0, 0,          0,            0, 0, 0, 1,  32'hC4,       32'hC8,  32'h0,   1, 0);
    add(1, 2, 32'h101,    0,            0, 0, 0, 1,  32'h100,      32'h104, 32'h0,   1, 0); // JALR bit0 cleared
    add(1, 0, 0,          0,            0, 0, 0, 1,  32'h104,      32'h108, 32'h0,   1, 0);
    add(1, 2, 32'h102,    0,            0, 0, 0, 1,  32'h100,      32'h104, 32'h104, 1, 1); // misaligned JALR
    add(1, 0, 0,          0,            0, 0, 0, 0,  32'h100,      32'h104, 32'h104, 1, 0); // pulse is one cycle
    add(1, 1, 0,          32'h200,      0, 0, 0, 0,  32'h200,      32'h204, 32'h104, 1, 0);
    add(1, 0, 0,          0,            0, 1, 1, 0,  32'h100,      32'h104, 32'h200, 1, 0); // trap beats mret
    add(1, 0, 0,          0,            0, 0, 0, 0,  32'h100,      32'h104, 32'h200, 1, 0);
    add(1, 0, 0,          0,            0, 0, 1, 0,  32'h200,      32'h204, 32'h200, 1, 0); // mret
    add(1, 1, 0,          32'hFFFFFFFC, 0, 0, 0, 0,  32'hFFFFFFFC, 32'h0,   32'h200, 1, 0);
    add(1, 0, 0,          0,            0, 0, 0, 1,  32'h0,        32'h4,   32'h200, 1, 0); // wrap
    add(0, 0, 0,          0,            0, 1, 0, 1,  32'h0,        32'h4,   32'h200, 1, 0); // en=0 ignores trap
    add(1, 1, 0,          32'h6,        0, 0, 0, 0,  32'h100,      32'h104, 32'h0,   1, 1); // misaligned PC_ADDER
    add(0, 1, 0,          32'h6,        0, 0, 0, 1,  32'h100,      32'h104, 32'h0,   1, 0); // en=0 clears pulse
    add(1, 3, 32'h40,     32'h40,       0, 0, 0, 1,  32'h104,      32'h108, 32'h0,   1, 0); // reserved = NOP
    add(1, 0, 0,          0,            1, 0, 0, 1,  32'h108,      32'h10C, 32'h0,   1, 0); // inst_len ignored
    do_reset();
    run_table(1'b0);

    // Phase B: compressed-capable instance.
    tab.delete();
    add(1, 0, 0,          0,            0, 0, 0, 1,  32'h80,       32'h84,  32'h0,   1, 0);
    add(1, 1, 0,          32'h10,       0, 0, 0, 0,  32'h10,       32'h14,  32'h0,   1, 0);
    add(0, 0, 0,          0,            0, 1, 0, 1,  32'h10,       32'h14,  32'h0,   1, 0); // frozen
    add(0, 0, 0,          0,            0, 1, 0, 1,  32'h10,       32'h14,  32'h0,   1, 0);
    add(1, 0, 0,          0,            1, 0, 0, 1,  32'h12,       32'h14,  32'h0,   1, 0); // 2-byte step
    add(1, 0, 0,          0,            1, 0, 0, 1,  32'h14,       32'h16,  32'h0,   1, 0);
    add(1, 0, 0,          0,            0, 0, 0, 1,  32'h18,       32'h1C,  32'h0,   1, 0); // 4-byte step
    add(1, 2, 32'h23,     0,            0, 0, 0, 0,  32'h22,       32'h26,  32'h0,   1, 0); // halfword aligned
    add(1, 1, 0,          32'h31,       0, 0, 0, 0,  32'h100,      32'h104, 32'h22,  1, 1); // odd target
    add(1, 0, 0,          0,            0, 0, 0, 0,  32'h100,      32'h104, 32'h22,  1, 0);
    do_reset();
    run_table(1'b1);

    // Asynchronous reset mid-operation, asserted between clock edges.
    idle_inputs();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_pc0", 0, pc0, 32'h80);
    chk("arst_pc1", 0, pc1, 32'h80);
    chk("arst_epc1", 0, epc1, 32'h0);
    chk("arst_fv0", 0, {31'd0, fv0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("boot_pc0", 0, pc0, 32'h80);
    chk("boot_fv0", 0, {31'd0, fv0}, 32'd1);
    @(posedge clk);
    #1;
    chk("boot_step_pc0", 0, pc0, 32'h84);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
